// File: rtl/tag_sram_clr.sv
// Tag SRAM, one RW port and one R port, with a hardware zero-sweep on reset or flush.
// Optional macro TAG_FORWARD_EN forwards a pending port 0 write onto port 1 reads.
module tag_sram_clr #(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 4,
  parameter int WMASK_WIDTH = 1
) (
  input  logic                   clk0,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  input  logic                   flush,
  output logic                   busy
);
  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  localparam int LW        = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    web0_reg;
  logic [WMASK_WIDTH-1:0]  wmask_reg;
  logic [ADDR_WIDTH-1:0]   addr0_reg;
  logic [DATA_WIDTH-1:0]   din0_reg;
  logic [ADDR_WIDTH-1:0]   addr1_reg;
  logic [DATA_WIDTH-1:0]   rd1;

  always_ff @(posedge clk0) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      else                clr_ptr <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = CLEAR;
      CLEAR:   if (clr_ptr == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // Flush sampled in IDLE still latches address/data, but never a write.
  always_ff @(posedge clk0) begin
    if (rst) begin
      web0_reg  <= 1'b1;
      wmask_reg <= '0;
      addr0_reg <= '0;
      din0_reg  <= '0;
      addr1_reg <= '0;
    end else if (state == CLEAR) begin
      web0_reg <= 1'b1;
    end else begin
      if (!csb0) begin
        web0_reg  <= web0 | flush;
        wmask_reg <= wmask0;
        addr0_reg <= addr0;
        din0_reg  <= din0;
      end else begin
        web0_reg <= 1'b1;
      end
      if (!csb1) addr1_reg <= addr1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (!web0_reg) begin
        for (int i = 0; i < WMASK_WIDTH; i++)
          if (wmask_reg[i]) mem[addr0_reg][i*LW +: LW] <= din0_reg[i*LW +: LW];
      end
    end
  end

  always_comb begin
    rd1 = mem[addr1_reg];
`ifdef TAG_FORWARD_EN
    if (!web0_reg && (addr1_reg == addr0_reg))
      for (int i = 0; i < WMASK_WIDTH; i++)
        if (wmask_reg[i]) rd1[i*LW +: LW] = din0_reg[i*LW +: LW];
`else
`endif
    dout1 = busy ? '0 : rd1;
    dout0 = busy ? '0 : mem[addr0_reg];
  end

endmodule

// File: tb/tb_tag_sram_clr.sv
// Bench for tag_sram_clr: countdown/array reference model checked every cycle plus literal spot checks.
module tb_tag_sram_clr;
  localparam int DW = 24;
  localparam int AW = 4;
  localparam int MW = 3;
  localparam int DEPTH = 16;

  logic          clk0 = 1'b0;
  logic          rst = 1'b1;
  logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1, flush = 1'b0;
  logic [MW-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0;
  logic [DW-1:0] dout0, dout1;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;

  tag_sram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) u_dut (
    .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0), .csb1(csb1), .addr1(addr1),
    .dout1(dout1), .flush(flush), .busy(busy)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Reference model: sweep_left counts remaining sweep cycles; memory is zeroed at sweep start
  // because nothing is observable or writable until the sweep finishes.
  logic [DW-1:0] m_mem [DEPTH];
  int            sweep_left = 0;
  bit            m_started = 0;
  bit            p_we = 0;
  logic [AW-1:0] p_addr = '0, a0 = '0, a1 = '0;
  logic [DW-1:0] p_din = '0;
  logic [MW-1:0] p_mask = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW; b++) if (m[b/(DW/MW)]) r[b] = nw[b];
    return r;
  endfunction

  initial forever begin
    @(posedge clk0);
    if (rst) begin
      m_started = 1;
      sweep_left = DEPTH;
      p_we = 0; a0 = '0; a1 = '0; p_din = '0; p_mask = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      p_we = 0;
    end else begin
      if (p_we) m_mem[p_addr] = merge(m_mem[p_addr], p_din, p_mask);
      if (flush) begin
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
      if (!csb0) begin
        p_we = !web0 && !flush;
        p_addr = addr0; p_din = din0; p_mask = wmask0; a0 = addr0;
      end else begin
        p_we = 0;
      end
      if (!csb1) a1 = addr1;
    end
  end

  initial forever begin
    logic [DW-1:0] e1;
    @(negedge clk0);
    if (m_started) begin
      e1 = m_mem[a1];
`ifdef TAG_FORWARD_EN
      if (p_we && a1 == p_addr) e1 = merge(e1, p_din, p_mask);
`endif
      if (sweep_left > 0) e1 = '0;
      chk("model_busy", 32'(busy), 32'(sweep_left > 0));
      chk("model_dout0", 32'(dout0), (sweep_left > 0) ? 32'd0 : 32'(m_mem[a0]));
      chk("model_dout1", 32'(dout1), 32'(e1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [DW-1:0] fwd_want;
    repeat (3) @(negedge clk0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_dout0", 32'(dout0), 32'd0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge clk0); end
    chk("rst_sweep_len", cnt, 16);

    for (int a = 0; a < DEPTH; a++) begin
      csb0 = 0; web0 = 1; addr0 = AW'(a); csb1 = 0; addr1 = AW'(a);
      @(negedge clk0);
    end
    csb0 = 1; csb1 = 1;

    // write addr 3 full word
    csb0 = 0; web0 = 0; addr0 = 4'd3; din0 = 24'hABCDEF; wmask0 = 3'b111;
    @(negedge clk0);
    chk("precommit_dout0", 32'(dout0), 32'h0);
    csb0 = 1; csb1 = 0; addr1 = 4'd3;
    @(negedge clk0);
    chk("commit_dout0", 32'(dout0), 32'hABCDEF);
    chk("p1_read_addr3", 32'(dout1), 32'hABCDEF);
    csb1 = 1;

    // lane-masked write
    csb0 = 0; web0 = 0; addr0 = 4'd7; din0 = 24'hFFFFFF; wmask0 = 3'b111;
    @(negedge clk0);
    din0 = 24'h000000; wmask0 = 3'b010;
    @(negedge clk0);
    web0 = 1;
    @(negedge clk0);
    chk("mask_mid_lane", 32'(dout0), 32'hFF00FF);
    csb0 = 1;

    // same-cycle write/read of addr 5
    csb0 = 0; web0 = 0; addr0 = 4'd5; din0 = 24'h123456; wmask0 = 3'b111; csb1 = 0; addr1 = 4'd5;
    @(negedge clk0);
`ifdef TAG_FORWARD_EN
    fwd_want = 24'h123456;
`else
    fwd_want = 24'h000000;
`endif
    chk("same_cycle_dout1", 32'(dout1), 32'(fwd_want));
    csb0 = 1; csb1 = 1;
    @(negedge clk0);
    chk("after_commit_dout1", 32'(dout1), 32'h123456);

    // partial-lane write with concurrent read
    csb0 = 0; web0 = 0; addr0 = 4'd7; din0 = 24'hAAAAAA; wmask0 = 3'b001; csb1 = 0; addr1 = 4'd7;
    @(negedge clk0);
    csb0 = 1;
    @(negedge clk0);
    chk("partial_lane0", 32'(dout1), 32'hFF00AA);
    csb1 = 1;

    // fill, then flush with a write registered on the flush edge
    for (int a = 0; a < DEPTH; a++) begin
      csb0 = 0; web0 = 0; addr0 = AW'(a); din0 = 24'h5A5A5A; wmask0 = 3'b111;
      @(negedge clk0);
    end
    csb0 = 0; web0 = 1; addr0 = 4'd9;
    @(negedge clk0);
    chk("filled_addr9", 32'(dout0), 32'h5A5A5A);
    flush = 1; csb0 = 0; web0 = 0; addr0 = 4'd2; din0 = 24'h111111;
    @(negedge clk0);
    flush = 0;
    cnt = 0;
    while (busy && cnt < 100) begin
      csb0 = 0; web0 = 1; addr0 = AW'(cnt); csb1 = 0; addr1 = AW'(cnt);
      flush = (cnt == 5);
      cnt++;
      @(negedge clk0);
    end
    flush = 0;
    chk("flush_sweep_len", cnt, 16);
    for (int a = 0; a < DEPTH; a++) begin
      csb0 = 0; web0 = 1; addr0 = AW'(a); csb1 = 0; addr1 = AW'(15 - a);
      @(negedge clk0);
    end
    csb0 = 0; addr0 = 4'd2;
    @(negedge clk0);
    chk("discarded_write_addr2", 32'(dout0), 32'h0);
    csb0 = 1; csb1 = 1;

    // reset mid-sweep restarts the sweep
    flush = 1;
    @(negedge clk0);
    flush = 0;
    repeat (8) @(negedge clk0);
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    rst = 1;
    @(negedge clk0);
    rst = 0;
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge clk0); end
    chk("rst_mid_sweep_len", cnt, 16);
    @(negedge clk0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tag_sram_clr.md
TAG_SRAM_CLR -- requirements
Module: tag_sram_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 24, bits per word.
REQ-002 Parameter ADDR_WIDTH, default 4, address bits; RAM_DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter WMASK_WIDTH, default 1, write-mask lanes; DATA_WIDTH SHALL be an integer multiple of WMASK_WIDTH; lane width LW = DATA_WIDTH/WMASK_WIDTH.
REQ-004 clk0  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 csb0  input  1  port 0 (RW) chip select, active low.
REQ-007 web0  input  1  port 0 write enable, active low.
REQ-008 wmask0  input  WMASK_WIDTH  port 0 lane write enables, active high.
REQ-009 addr0  input  ADDR_WIDTH  port 0 address.
REQ-010 din0  input  DATA_WIDTH  port 0 write data.
REQ-011 dout0  output  DATA_WIDTH  port 0 read data.
REQ-012 csb1  input  1  port 1 (R) chip select, active low.
REQ-013 addr1  input  ADDR_WIDTH  port 1 address.
REQ-014 dout1  output  DATA_WIDTH  port 1 read data.
REQ-015 flush  input  1  request to zero every entry, active high, single-cycle pulse sufficient.
REQ-016 busy  output  1  high while clear sweep in progress; ports ignored.

Function
REQ-017 Clear FSM SHALL have states IDLE and CLEAR, with pointer clr_ptr of ADDR_WIDTH bits.
REQ-018 In CLEAR, each posedge SHALL write all-zero to mem[clr_ptr] and increment clr_ptr.
REQ-019 CLEAR with clr_ptr == RAM_DEPTH-1 SHALL write that entry and go to IDLE; busy low next cycle; sweep = exactly RAM_DEPTH cycles.
REQ-020 IDLE with flush=1 at posedge SHALL enter CLEAR with clr_ptr=0; flush during CLEAR SHALL be ignored (no restart).
REQ-021 busy SHALL equal (state == CLEAR).
REQ-022 When busy=0 and csb0=0 at posedge N, web0/wmask0/addr0/din0 SHALL be registered; when csb0=1, registers hold except web0_reg, which SHALL be set to 1.
REQ-023 A registered write (web0_reg=0) SHALL commit at posedge N+1, updating only lanes i with wmask_reg[i]=1 (bits i*LW+LW-1 : i*LW).
REQ-024 dout0 SHALL be combinational mem[addr0_reg]; valid after posedge N, reflecting the committed write from N+1 onward.
REQ-025 When busy=0 and csb1=0 at posedge N, addr1 SHALL be registered; dout1 = mem[addr1_reg] combinationally; csb1=1 holds addr1_reg.
REQ-026 While busy=1, csb0/csb1 SHALL be ignored, web0_reg forced 1, no user write committed, dout0 and dout1 driven to 0.
REQ-027 A write registered at the posedge where flush is sampled SHALL be discarded (web0_reg forced 1 on CLEAR entry).
REQ-028 Simultaneous port 0 write and port 1 read of the same address SHALL return old data on dout1 until commit (unless REQ-034).

Reset
REQ-029 rst=1 at posedge SHALL set state=CLEAR, clr_ptr=0, web0_reg=1, addr0_reg=0, addr1_reg=0, wmask_reg=0, din0_reg=0.
REQ-030 While rst held high, clr_ptr SHALL stay 0 and busy=1; sweep begins on first posedge with rst=0.
REQ-031 rst asserted mid-sweep SHALL restart the sweep from clr_ptr=0.
REQ-032 Outputs after reset: busy=1, dout0=0, dout1=0 until sweep completes.

Configuration
REQ-033 Macro TAG_FORWARD_EN controls port 1 write forwarding.
REQ-034 With TAG_FORWARD_EN defined: when busy=0, web0_reg=0 and addr1_reg==addr0_reg, dout1 SHALL equal mem[addr1_reg] with masked lanes replaced by din0_reg lanes.
REQ-035 Without TAG_FORWARD_EN: dout1 SHALL be mem[addr1_reg] only (REQ-028 behaviour).

Verification
REQ-036 Deassert rst -> busy high exactly 16 cycles (defaults), then low; all 16 entries read 0 on both ports.
REQ-037 Write addr 3 din 0xABCDEF, wmask 1 -> dout0 at addr 3 = 0xABCDEF from commit edge; port 1 read addr 3 = 0xABCDEF next cycle.
REQ-038 WMASK_WIDTH=3, entry 0xFFFFFF, write din 0x000000 wmask 3'b010 -> entry reads 0xFF00FF.
REQ-039 Fill entries with 0x5A5A5A, pulse flush -> busy 16 cycles, dout0/dout1 = 0 during sweep, all entries 0 after; second flush mid-sweep does not extend busy.
REQ-040 Same-cycle port 0 write 0x123456 and port 1 read addr 5 (old 0x000000) -> dout1 = 0x123456 in registered cycle with TAG_FORWARD_EN, 0x000000 without.
REQ-041 rst pulsed at sweep cycle 8 -> busy stays high 16 further cycles after rst low.
